// File: rtl/strassen_pkg.sv
// rtl/strassen_pkg.sv - shared widths and divider state type for the Strassen datapath
package strassen_pkg;

  // Product (dividend/quotient) and operand (divisor/remainder) widths
  localparam int PROD_W = 8;
  localparam int OPND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step
module div_restore_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          q_bit
);

  logic [VW:0]   shifted;
  logic [VW-1:0] diff;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  // Since rem < divisor, the shifted value is at most 2*divisor-1, so the
  // difference always fits in VW bits and can be taken modulo 2^VW.
  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {1'b0, divisor});
    diff     = shifted[VW-1:0] - divisor;
    rem_next = q_bit ? diff : shifted[VW-1:0];
  end

endmodule

// File: rtl/seq_div_8by4.sv
// rtl/seq_div_8by4.sv - sequential restoring divider, 8-bit product by 4-bit operand
module seq_div_8by4
  import strassen_pkg::*;
#(
  parameter int DW = PROD_W,
  parameter int VW = OPND_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          q_ovf
);

  localparam int CW = $clog2(DW);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  logic [VW-1:0] rem_r;
  logic [DW-1:0] q_r;

  logic [VW-1:0] rem_next;
  logic          q_bit;
  logic [DW-1:0] q_next;

  div_restore_step #(.VW(VW)) u_step (
    .rem      (rem_r),
    .bit_in   (dvd_r[cnt]),
    .divisor  (dvs_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Quotient bits arrive MSB first, so shifting left places bit cnt correctly
  assign q_next   = {q_r[DW-2:0], q_bit};
  assign in_ready = (state == IDLE);

  // FSM, working registers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            rem_r <= '0;
            q_r   <= '0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              div_zero  <= 1'b1;
              q_ovf     <= 1'b0;
            end else begin
              state <= CALC;
              cnt   <= CW'(DW - 1);
            end
          end
        end
        CALC: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= rem_next;
            div_zero  <= 1'b0;
            q_ovf     <= |q_next[DW-1:VW];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_8by4.sv
// tb/tb_seq_div_8by4.sv - self-checking bench for seq_div_8by4
module tb_seq_div_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;
  logic       q_ovf;

  int checks = 0;
  int errors = 0;

  seq_div_8by4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .q_ovf     (q_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operation, return edges from the accepting edge to out_valid
  task automatic start_op(input logic [7:0] dd, input logic [3:0] dv, output int edges);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("in_ready_before_op", int'(in_ready), 1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // With out_ready high the result pops on the next edge
  task automatic pop_check();
    @(posedge clk); #1;
    chk("out_valid_after_pop", int'(out_valid), 0);
    chk("in_ready_after_pop", int'(in_ready), 1);
  endtask

  initial begin
    int edges;
    logic [7:0] hq;
    logic [3:0] hr;
    logic hdz, hovf;

    //        dd     dv     q      r     dz    ovf   lat
    vecs[0]  = '{8'd200, 4'd13, 8'd15,  4'd5, 1'b0, 1'b0, 9};
    vecs[1]  = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 1'b0, 9};
    vecs[2]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 1'b1, 9};
    vecs[3]  = '{8'd0,   4'd7,  8'd0,   4'd0, 1'b0, 1'b0, 9};
    vecs[4]  = '{8'd7,   4'd0,  8'hFF,  4'd7, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'd100, 4'd9,  8'd11,  4'd1, 1'b0, 1'b0, 9};
    vecs[6]  = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 1'b0, 9};
    vecs[7]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 1'b1, 9};
    vecs[8]  = '{8'd16,  4'd3,  8'd5,   4'd1, 1'b0, 1'b0, 9};
    vecs[9]  = '{8'd254, 4'd13, 8'd19,  4'd7, 1'b0, 1'b1, 9};
    vecs[10] = '{8'd9,   4'd10, 8'd0,   4'd9, 1'b0, 1'b0, 9};
    vecs[11] = '{8'd188, 4'd0,  8'hFF,  4'd12, 1'b1, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_div_zero", int'(div_zero), 0);
    chk("reset_q_ovf", int'(q_ovf), 0);
    rst = 1'b0;

    // Cross-check the operands of vector 1 really form a 4x4 product
    chk("product_13x11", int'(vecs[1].q) * int'(vecs[1].dv), int'(vecs[1].dd));

    // Directed table
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].dd, vecs[i].dv, edges);
      chk($sformatf("latency[%0d]", i), edges, vecs[i].lat);
      chk($sformatf("quotient[%0d]", i), int'(quotient), int'(vecs[i].q));
      chk($sformatf("remainder[%0d]", i), int'(remainder), int'(vecs[i].r));
      chk($sformatf("div_zero[%0d]", i), int'(div_zero), int'(vecs[i].dz));
      chk($sformatf("q_ovf[%0d]", i), int'(q_ovf), int'(vecs[i].ovf));
      pop_check();
    end

    // Backpressure: result held for 5 cycles with out_ready low
    out_ready = 1'b0;
    start_op(8'd200, 4'd13, edges);
    chk("bp_latency", edges, 9);
    hq = quotient; hr = remainder; hdz = div_zero; hovf = q_ovf;
    chk("bp_quotient", int'(hq), 15);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_quotient_stable", int'(quotient), int'(hq));
      chk("bp_remainder_stable", int'(remainder), int'(hr));
      chk("bp_flags_stable", int'({div_zero, q_ovf}), int'({hdz, hovf}));
    end
    out_ready = 1'b1;
    pop_check();

    // Reset during CALC: accepting edge plus 3 more, reset on the 4th cycle
    dividend = 8'd200; divisor = 4'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_calc_busy", int'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_flags", int'({div_zero, q_ovf}), 0);
    start_op(8'd100, 4'd9, edges);
    chk("post_abort_latency", edges, 9);
    chk("post_abort_quotient", int'(quotient), 11);
    chk("post_abort_remainder", int'(remainder), 1);
    pop_check();

    // Random vectors against a behavioural reference
    for (int n = 0; n < 2000; n++) begin
      int a, b;
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(15, 1));
      start_op(8'(a), 4'(b), edges);
      chk("rand_latency", edges, 9);
      chk("rand_identity", int'(quotient) * b + int'(remainder), a);
      chk("rand_rem_lt_div", int'(int'(remainder) < b), 1);
      chk("rand_quotient", int'(quotient), a / b);
      chk("rand_q_ovf", int'(q_ovf), int'((a / b) > 15));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
